// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a handshaked instruction-memory
// port, buffers one fetched word for decode, handles redirects and HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted
);

  // state  | meaning
  // IDLE   | first cycle out of reset, no request
  // FETCH  | request at pc whenever the output buffer is free
  // SQUASH | finish a redirected-away request, discard its data
  // HALT   | HALT accepted, fetch stopped until reset
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SQUASH, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] req_addr, req_addr_nxt;
  logic        accept, halt_hit, capture, buf_clear;
  logic [15:0] target;

  assign accept    = instr_valid & ~stall;
  assign target    = {redirect_pc[15:1], 1'b0};
  assign imem_addr = req_addr;
  assign halt_hit  = accept & (instr_out[15:11] == 5'd0) & ~redirect_valid &
                     ((state == S_FETCH) | (state == S_SQUASH));

  always_comb begin
    imem_req = 1'b0;
    case (state)
      S_FETCH:  imem_req = ~instr_valid | ~stall;
      S_SQUASH: imem_req = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    buf_clear = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
        if (redirect_valid) pc_nxt = target;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          buf_clear = 1'b1;
          state_nxt = (imem_req & ~imem_ready) ? S_SQUASH : S_FETCH;
        end else if (halt_hit) begin
          state_nxt = S_HALT;
          buf_clear = 1'b1;
        end else if (imem_req & imem_ready) begin
          capture = 1'b1;
          pc_nxt  = pc + 16'd2;
        end
      end
      S_SQUASH: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          buf_clear = 1'b1;
          if (imem_ready) state_nxt = S_FETCH;
        end else if (halt_hit) begin
          state_nxt = S_HALT;
          buf_clear = 1'b1;
        end else if (imem_ready) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_HALT;
    endcase
    // While squashing, the old address must stay on the bus until ready
    req_addr_nxt = (state_nxt == S_SQUASH) ? req_addr : pc_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr_out   <= NOP_WORD;
      pc_plus2    <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      halted   <= (state_nxt == S_HALT);
      if (buf_clear) begin
        instr_valid <= 1'b0;
        instr_out   <= NOP_WORD;
      end else if (capture) begin
        instr_valid <= 1'b1;
        instr_out   <= imem_rdata;
        pc_plus2    <= pc + 16'd2;
      end else if (accept) begin
        instr_valid <= 1'b0;
        instr_out   <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with fixed expectations, then
// random stall/wait/redirect traffic checked against a program-order model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        halted;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_plus2(pc_plus2),
    .instr_valid(instr_valid), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory content: unique per even address, bit 15 set so never a HALT word
  function automatic logic [15:0] word(input logic [15:0] a);
    return {1'b1, a[15:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [15:0] rp,
                       input logic rdy, input logic [15:0] rd);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ready     = rdy;
    imem_rdata     = rd;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  logic        busy, prev_pend;
  int          wl, accepts;
  logic [15:0] prev_addr, exp_addr, acc_a;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
    edge_step();
    edge_step();
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc2", pc_plus2, 0);
    check("rst_halted", halted, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    rst = 1'b1;
    edge_step();

    // zero-wait streaming; the word at address 6 is replaced by 16'h4123
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, (i == 3) ? 16'h4123 : word(imem_addr));
      check("stream_req", imem_req, 1);
      check("stream_addr", imem_addr, 32'(2 * i));
      if (i > 0) begin
        check("stream_valid", instr_valid, 1);
        check("stream_pc2", pc_plus2, 32'(2 * i));
        check("stream_instr", instr_out, word(16'(2 * i - 2)));
      end
      edge_step();
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      check("stall_req", imem_req, 0);
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr_out, 16'h4123);
      check("stall_pc2", pc_plus2, 16'h0008);
      edge_step();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'h0008));
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 16'h0008);
    edge_step();

    // two wait states on address A, redirect to 0x0041 during the wait
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'hDEAD);
    check("w_instr", instr_out, word(16'h0008));
    check("w_addr0", imem_addr, 16'h000A);
    edge_step();
    drive(1'b0, 1'b1, 16'h0041, 1'b0, 16'hDEAD);
    check("w_req1", imem_req, 1);
    check("w_addr1", imem_addr, 16'h000A);
    check("w_valid1", instr_valid, 0);
    edge_step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'h000A));
    check("sq_req", imem_req, 1);
    check("sq_addr", imem_addr, 16'h000A);
    check("sq_valid", instr_valid, 0);
    edge_step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'h0040));
    check("tgt_addr", imem_addr, 16'h0040);
    check("tgt_valid", instr_valid, 0);
    edge_step();

    // HALT word accepted in the same cycle as a redirect
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
    check("tgt_instr", instr_out, word(16'h0040));
    check("tgt_pc2", pc_plus2, 16'h0042);
    edge_step();
    drive(1'b0, 1'b1, 16'h0100, 1'b1, word(16'h0044));
    check("hr_instr", instr_out, 16'h0000);
    edge_step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'h0100));
    check("hr_halted", halted, 0);
    check("hr_valid", instr_valid, 0);
    check("hr_addr", imem_addr, 16'h0100);
    check("hr_req", imem_req, 1);
    edge_step();

    // wrap at the top of the address space
    drive(1'b0, 1'b1, 16'hFFFF, 1'b1, word(16'h0102));
    check("hr_instr2", instr_out, word(16'h0100));
    edge_step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'hFFFE));
    check("wrap_addr0", imem_addr, 16'hFFFE);
    edge_step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
    check("wrap_addr1", imem_addr, 16'h0000);
    check("wrap_pc2", pc_plus2, 16'h0000);
    check("wrap_instr", instr_out, word(16'hFFFE));
    edge_step();

    // HALT accepted alone
    drive(1'b0, 1'b0, 16'h0, 1'b1, word(16'h0002));
    check("halt_word", instr_out, 16'h0000);
    edge_step();
    for (int k = 0; k < 4; k++) begin
      drive(1'($urandom_range(0, 1)), (k == 1), 16'h0200, 1'b0, 16'h0);
      check("halt_flag", halted, 1);
      check("halt_req", imem_req, 0);
      edge_step();
    end
    #2 rst = 1'b0;
    #1;
    check("arst_halted", halted, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_instr", instr_out, NOP);
    check("arst_addr", imem_addr, 16'h0000);
    edge_step();
    rst = 1'b1;

    // random traffic against an in-order program model
    busy = 1'b0; prev_pend = 1'b0; wl = 0; accepts = 0;
    prev_addr = 16'h0; exp_addr = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 16'($urandom);
      imem_ready     = 1'b0;
      imem_rdata     = 16'($urandom);
      #1;
      if (prev_pend) begin
        check("hold_req", imem_req, 1);
        check("hold_addr", imem_addr, prev_addr);
      end
      if (imem_req) begin
        check("addr_align", imem_addr[0], 0);
        if (!busy) begin
          busy = 1'b1;
          wl   = $urandom_range(0, 2);
        end
        if (wl == 0) begin
          imem_ready = 1'b1;
          imem_rdata = word(imem_addr);
          busy       = 1'b0;
        end else begin
          wl--;
        end
      end
      prev_pend = imem_req && !imem_ready;
      prev_addr = imem_addr;
      check("no_halt", halted, 0);
      if (instr_valid && !stall) begin
        accepts++;
        acc_a = pc_plus2 - 16'd2;
        check("acc_addr", acc_a, exp_addr);
        check("acc_data", instr_out, word(acc_a));
        exp_addr = exp_addr + 16'd2;
      end
      if (redirect_valid) exp_addr = redirect_pc & 16'hFFFE;
      edge_step();
    end
    check("progress", (accepts > 300), 1);

    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", instr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
